// File: rtl/dstb_pkg.sv
// Shared definitions for the fast-RAM bus front end: FSM states, active-low levels, default window.
// No latency or backpressure of its own; it holds only types and constants.
package dstb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDPIPE,
        ST_ACK,
        ST_ERR,
        ST_END
    } state_t;

    localparam logic ACT_L   = 1'b0;
    localparam logic INACT_L = 1'b1;

    localparam logic [2:0] WIN_LO_DEF = 3'd1;
    localparam logic [2:0] WIN_HI_DEF = 3'd4;

    function automatic logic in_window(input logic [2:0] a_hi,
                                       input logic [2:0] lo,
                                       input logic [2:0] hi);
        return (a_hi >= lo) && (a_hi <= hi);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an active-low CPU strobe; resets to the inactive level (1).
// Latency: 2 CLK edges. No backpressure.
module sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/st_fastram_bus_if.sv
// 68000 fast-RAM front end: syncs CPU strobes, gates them to the SDRAM controller, returns DTACK/BERR.
// Latency: AS pin to RAM_AS 3 edges. No backpressure; the CPU is held off by withholding DTACK.
module st_fastram_bus_if
    import dstb_pkg::*;
#(
    parameter logic [2:0] WIN_LO  = WIN_LO_DEF,
    parameter logic [2:0] WIN_HI  = WIN_HI_DEF,
    parameter int         RD_LAT  = 4,
    parameter int         TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AS,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        RW,
    input  logic [22:0] A,
    input  logic        VALID,
    input  logic        READY,
    output logic        RAM_AS,
    output logic        RAM_UDS,
    output logic        RAM_LDS,
    output logic        DTACK,
    output logic        BERR,
    output logic        DQ_LE,
    output logic        DBUF_OE,
    output logic        DBUF_DIR
);

    localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic   as_s;
    logic   uds_s;
    logic   lds_s;
    logic   hit;
    logic   unused_addr;
    logic   rw_q;
    logic   [7:0] cnt;
    state_t state;

    sync2 u_sync_as  (.CLK(CLK), .RST(RST), .d(AS),  .q(as_s));
    sync2 u_sync_uds (.CLK(CLK), .RST(RST), .d(UDS), .q(uds_s));
    sync2 u_sync_lds (.CLK(CLK), .RST(RST), .d(LDS), .q(lds_s));

    // A is stable for the whole bus cycle, so it is used directly at the request decision.
    assign hit = (as_s == ACT_L) && in_window(A[22:20], WIN_LO, WIN_HI) &&
                 ((uds_s == ACT_L) || (lds_s == ACT_L));

    // Row/column bits are decoded by the controller, not here.
    assign unused_addr = ^A[19:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            rw_q     <= 1'b1;
            RAM_AS   <= INACT_L;
            RAM_UDS  <= INACT_L;
            RAM_LDS  <= INACT_L;
            DTACK    <= INACT_L;
            BERR     <= INACT_L;
            DQ_LE    <= 1'b0;
            DBUF_OE  <= INACT_L;
            DBUF_DIR <= 1'b1;
        end else begin
            DQ_LE <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (hit && !READY) begin
                        state    <= ST_REQ;
                        RAM_AS   <= ACT_L;
                        RAM_UDS  <= uds_s;
                        RAM_LDS  <= lds_s;
                        DBUF_DIR <= RW;
                        rw_q     <= RW;
                        cnt      <= 8'd0;
                    end
                end
                ST_REQ: begin
                    // Abort beats VALID, and VALID beats an expiring timeout.
                    if (as_s) begin
                        state   <= ST_END;
                        RAM_AS  <= INACT_L;
                        RAM_UDS <= INACT_L;
                        RAM_LDS <= INACT_L;
                    end else if (!VALID) begin
                        if (rw_q) begin
                            state <= ST_RDPIPE;
                            cnt   <= RD_LOAD;
                        end else begin
                            state   <= ST_ACK;
                            DTACK   <= ACT_L;
                            DBUF_OE <= ACT_L;
                        end
                    end else if (cnt == TO_LAST) begin
                        state   <= ST_ERR;
                        BERR    <= ACT_L;
                        RAM_AS  <= INACT_L;
                        RAM_UDS <= INACT_L;
                        RAM_LDS <= INACT_L;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RDPIPE: begin
                    if (as_s) begin
                        state   <= ST_END;
                        RAM_AS  <= INACT_L;
                        RAM_UDS <= INACT_L;
                        RAM_LDS <= INACT_L;
                    end else if (cnt <= 8'd1) begin
                        state <= ST_ACK;
                        cnt   <= 8'd0;
                        DQ_LE <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ACK: begin
                    if (as_s) begin
                        state   <= ST_END;
                        DTACK   <= INACT_L;
                        DBUF_OE <= INACT_L;
                        RAM_AS  <= INACT_L;
                        RAM_UDS <= INACT_L;
                        RAM_LDS <= INACT_L;
                    end else begin
                        DTACK   <= ACT_L;
                        DBUF_OE <= ACT_L;
                    end
                end
                ST_ERR: begin
                    if (as_s) begin
                        state <= ST_END;
                        BERR  <= INACT_L;
                    end
                end
                ST_END: begin
                    // One idle slot so the controller always samples RAM_AS high between cycles.
                    state    <= ST_IDLE;
                    RAM_AS   <= INACT_L;
                    RAM_UDS  <= INACT_L;
                    RAM_LDS  <= INACT_L;
                    DTACK    <= INACT_L;
                    BERR     <= INACT_L;
                    DBUF_OE  <= INACT_L;
                    DBUF_DIR <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_st_fastram_bus_if.sv
// Directed bench for st_fastram_bus_if: vector table of CPU cycles plus timeout, READY, abort and reset sequences.
module tb_st_fastram_bus_if;

    localparam int RD_LAT  = 4;
    localparam int TIMEOUT = 255;
    localparam int S_RAS   = 0;
    localparam int S_DTACK = 1;
    localparam int S_BERR  = 2;
    localparam int S_DQLE  = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        AS, UDS, LDS, RW;
    logic [22:0] A;
    logic        VALID, READY;
    logic        RAM_AS, RAM_UDS, RAM_LDS, DTACK, BERR, DQ_LE, DBUF_OE, DBUF_DIR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] addr;
        logic        rw;
        logic        uds;
        logic        lds;
        int          vdly;
        logic        hit;
        logic        exp_uds;
        logic        exp_lds;
        logic        exp_dir;
    } vec_t;

    vec_t vt [8];

    st_fastram_bus_if #(
        .WIN_LO(3'd1), .WIN_HI(3'd4), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .A(A),
        .VALID(VALID), .READY(READY),
        .RAM_AS(RAM_AS), .RAM_UDS(RAM_UDS), .RAM_LDS(RAM_LDS), .DTACK(DTACK),
        .BERR(BERR), .DQ_LE(DQ_LE), .DBUF_OE(DBUF_OE), .DBUF_DIR(DBUF_DIR)
    );

    always #5 CLK = ~CLK;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_RAS:   return RAM_AS;
            S_DTACK: return DTACK;
            S_BERR:  return BERR;
            S_DQLE:  return DQ_LE;
            default: return 1'bx;
        endcase
    endfunction

    // Counts falling edges until the selected output reaches val; -1 if the budget runs out.
    task automatic wait_sig(input int sel, input logic val, input int maxn, output int n);
        n = -1;
        for (int i = 1; i <= maxn; i++) begin
            @(negedge CLK);
            if (sig(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic start_cycle(input logic [23:0] addr, input logic rw,
                               input logic uds, input logic lds);
        logic [23:0] a;
        a   = addr;
        A   = a[23:1];
        RW  = rw;
        UDS = uds;
        LDS = lds;
        AS  = 1'b0;
    endtask

    task automatic end_cycle();
        AS    = 1'b1;
        UDS   = 1'b1;
        LDS   = 1'b1;
        VALID = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int bad;
        @(negedge CLK);
        start_cycle(v.addr, v.rw, v.uds, v.lds);
        if (v.hit) begin
            wait_sig(S_RAS, 1'b0, 8, n);
            check_int($sformatf("v%0d_ras_lat", idx), n, 3);
            check_bit($sformatf("v%0d_ram_uds", idx), RAM_UDS, v.exp_uds);
            check_bit($sformatf("v%0d_ram_lds", idx), RAM_LDS, v.exp_lds);
            check_bit($sformatf("v%0d_dbuf_dir", idx), DBUF_DIR, v.exp_dir);
            repeat (v.vdly) @(negedge CLK);
            VALID = 1'b0;
            if (v.rw) begin
                wait_sig(S_DQLE, 1'b1, 12, n);
                check_int($sformatf("v%0d_dq_le_lat", idx), n, RD_LAT);
                wait_sig(S_DTACK, 1'b0, 1, n);
                check_int($sformatf("v%0d_rd_dtack_lat", idx), n, 1);
                check_bit($sformatf("v%0d_dq_le_pulse", idx), DQ_LE, 1'b0);
            end else begin
                wait_sig(S_DTACK, 1'b0, 8, n);
                check_int($sformatf("v%0d_wr_dtack_lat", idx), n, 1);
            end
            check_bit($sformatf("v%0d_dbuf_oe", idx), DBUF_OE, 1'b0);
            end_cycle();
            wait_sig(S_DTACK, 1'b1, 6, n);
            check_int($sformatf("v%0d_dtack_rel", idx), n, 3);
            check_bit($sformatf("v%0d_ras_rel", idx), RAM_AS, 1'b1);
        end else begin
            bad = 0;
            repeat (20) begin
                @(negedge CLK);
                if (RAM_AS !== 1'b1 || DTACK !== 1'b1 || BERR !== 1'b1) bad++;
            end
            check_int($sformatf("v%0d_miss_quiet", idx), bad, 0);
            end_cycle();
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        //          addr          rw    uds   lds   vdly hit   euds  elds  edir
        vt[0] = '{24'h200000, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{24'h3FFFFE, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{24'h9FFFFE, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{24'h800000, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[4] = '{24'h1FFFFE, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[5] = '{24'hA00000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[6] = '{24'hFA0000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[7] = '{24'h200000, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1};

        AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; A = '0;
        VALID = 1'b1; READY = 1'b0; RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_vec("rst_outputs",
                  {RAM_AS, RAM_UDS, RAM_LDS, DTACK, BERR, DBUF_OE, DQ_LE, DBUF_DIR}, 8'b1111_1101);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Controller never accepts: bus error after TIMEOUT request cycles.
        @(negedge CLK);
        start_cycle(24'h400000, 1'b0, 1'b0, 1'b0);
        wait_sig(S_RAS, 1'b0, 8, n);
        check_int("to_ras_lat", n, 3);
        wait_sig(S_BERR, 1'b0, TIMEOUT + 20, n);
        check_int("to_berr_lat", n, TIMEOUT);
        check_bit("to_ras_released", RAM_AS, 1'b1);
        check_bit("to_no_dtack", DTACK, 1'b1);
        end_cycle();
        wait_sig(S_BERR, 1'b1, 6, n);
        check_int("to_berr_rel", n, 3);
        repeat (3) @(negedge CLK);

        // Controller still initialising: request held off, no timeout.
        READY = 1'b1;
        @(negedge CLK);
        start_cycle(24'h200000, 1'b0, 1'b0, 1'b0);
        bad = 0;
        repeat (300) begin
            @(negedge CLK);
            if (RAM_AS !== 1'b1 || BERR !== 1'b1) bad++;
        end
        check_int("rdy_hold", bad, 0);
        READY = 1'b0;
        wait_sig(S_RAS, 1'b0, 4, n);
        check_int("rdy_issue", n, 1);
        VALID = 1'b0;
        wait_sig(S_DTACK, 1'b0, 4, n);
        check_int("rdy_dtack", n, 1);
        end_cycle();
        wait_sig(S_DTACK, 1'b1, 6, n);
        check_int("rdy_dtack_rel", n, 3);
        repeat (3) @(negedge CLK);

        // CPU drops AS before completion, with a late VALID: no DTACK, no DQ_LE.
        @(negedge CLK);
        start_cycle(24'h200000, 1'b1, 1'b0, 1'b0);
        wait_sig(S_RAS, 1'b0, 8, n);
        check_int("ab_ras_lat", n, 3);
        end_cycle();
        @(negedge CLK);
        VALID = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DTACK !== 1'b1 || DQ_LE !== 1'b0 || BERR !== 1'b1) bad++;
        end
        VALID = 1'b1;
        check_int("ab_quiet", bad, 0);
        check_bit("ab_ras_released", RAM_AS, 1'b1);
        repeat (3) @(negedge CLK);

        // Asynchronous reset in the middle of the read pipeline.
        @(negedge CLK);
        start_cycle(24'h200000, 1'b1, 1'b0, 1'b0);
        wait_sig(S_RAS, 1'b0, 8, n);
        check_int("rs_ras_lat", n, 3);
        VALID = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check_vec("rs_async",
                  {RAM_AS, RAM_UDS, RAM_LDS, DTACK, BERR, DBUF_OE, DQ_LE, DBUF_DIR}, 8'b1111_1101);
        end_cycle();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        run_vec(vt[0], 8);
        run_vec(vt[1], 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
